// File: rtl/debounce.sv
// ============================================================================
// debounce
// ----------------------------------------------------------------------------
// Single-clock input debouncer with registered edge strobes. A new input
// value must be sampled STABLE_CYCLES times in a row before the debounced
// level follows it. The level change is announced by a one-cycle strobe:
// oQ on a 0->1 change, oFall on a 1->0 change. In the display controller this
// turns the resynchronized 4 MHz MCK into one dot-clock enable per MCK period.
//
// Parameters:
//   STABLE_CYCLES  consecutive differing samples needed to accept a new level
//                  (1..255; keep below the shortest input half-period)
//   INIT_LEVEL     debounced level loaded at reset
//
// Ports:
//   iClk    in   system clock, rising-edge active
//   iRst_n  in   asynchronous active-low reset
//   iD      in   raw input, already synchronous to iClk (no synchronizer here)
//   oQ      out  one-cycle pulse on a qualified rising transition
//   oLevel  out  debounced level
//   oFall   out  one-cycle pulse on a qualified falling transition
// ============================================================================
module debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iD,
    output logic oQ,
    output logic oLevel,
    output logic oFall
);

    // Wide enough to hold STABLE_CYCLES; in practice it tops out at
    // STABLE_CYCLES-1 because reaching that value commits the new level.
    localparam int unsigned    CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // Number of consecutive samples seen so far that differ from oLevel.
    logic [CNT_W-1:0] stableCnt;

    // The level register doubles as the reference the input is compared
    // against, so oLevel is registered with no extra output stage. The
    // strobes are written on every edge, so they can only ever last one
    // cycle, and only one of them can be set by any single level change.
    // NOTE: every register here is assigned with <= so all of them update
    // from the same pre-edge values; a blocking '=' would let the strobe
    // logic see the already-updated level.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            // Any partial count is discarded; iD is not looked at here, so an
            // undriven input during reset cannot reach the outputs.
            oLevel    <= INIT_LEVEL;
            stableCnt <= '0;
            oQ        <= 1'b0;
            oFall     <= 1'b0;
        end else if (iD == oLevel) begin
            // A single agreeing sample restarts the run: glitch runs are not
            // accumulated across interruptions.
            stableCnt <= '0;
            oQ        <= 1'b0;
            oFall     <= 1'b0;
        end else if (stableCnt == CNT_LAST) begin
            // Nth consecutive differing sample: accept the new value.
            oLevel    <= iD;
            stableCnt <= '0;
            oQ        <= iD;
            oFall     <= ~iD;
        end else begin
            stableCnt <= stableCnt + 1'b1;
            oQ        <= 1'b0;
            oFall     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce.sv
// ============================================================================
// tb_debounce
// ----------------------------------------------------------------------------
// Two instances: N=4 (the display-controller build) and N=1 (pure registered
// edge detector). A behavioural model per instance keeps the history of
// samples since the last accepted level change and flips its level when the
// most recent N samples all disagree with it. The DUT outputs are compared
// against the model on every falling clock edge; directed phases add
// hand-computed literal expectations that pin the model.
// ============================================================================
module tb_debounce;

    logic clk;
    logic rst_n;
    logic d4, d1;
    logic q4, level4, fall4;
    logic q1, level1, fall1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    debounce #(.STABLE_CYCLES(4), .INIT_LEVEL(1'b0)) dut4 (
        .iClk(clk), .iRst_n(rst_n), .iD(d4),
        .oQ(q4), .oLevel(level4), .oFall(fall4)
    );

    debounce #(.STABLE_CYCLES(1), .INIT_LEVEL(1'b0)) dut1 (
        .iClk(clk), .iRst_n(rst_n), .iD(d1),
        .oQ(q1), .oLevel(level1), .oFall(fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the level flips when the last N samples recorded
    // since the previous flip (or reset) all differ from it.
    // ------------------------------------------------------------------
    function automatic bit lastAllDiffer(input bit hist[$], input int n, input bit lvl);
        if (hist.size() < n) return 1'b0;
        for (int i = 0; i < n; i++)
            if (hist[hist.size() - 1 - i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    bit h4[$], h1[$];
    bit m4Level, m4Q, m4Fall;
    bit m1Level, m1Q, m1Fall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h4.delete(); m4Level = 1'b0; m4Q = 1'b0; m4Fall = 1'b0;
            h1.delete(); m1Level = 1'b0; m1Q = 1'b0; m1Fall = 1'b0;
        end else begin
            h4.push_back(bit'(d4));
            if (h4.size() > 64) void'(h4.pop_front());
            m4Q = 1'b0; m4Fall = 1'b0;
            if (lastAllDiffer(h4, 4, m4Level)) begin
                m4Level = ~m4Level;
                if (m4Level) m4Q = 1'b1; else m4Fall = 1'b1;
                h4.delete();
            end

            h1.push_back(bit'(d1));
            if (h1.size() > 64) void'(h1.pop_front());
            m1Q = 1'b0; m1Fall = 1'b0;
            if (lastAllDiffer(h1, 1, m1Level)) begin
                m1Level = ~m1Level;
                if (m1Level) m1Q = 1'b1; else m1Fall = 1'b1;
                h1.delete();
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare plus pulse bookkeeping for the directed checks.
    // ------------------------------------------------------------------
    int q4Count = 0, f4Count = 0, q1Count = 0, f1Count = 0;
    int q4Times[$];

    always @(negedge clk) begin
        check("n4_outputs{q,level,fall}", {29'd0, q4, level4, fall4}, {29'd0, m4Q, m4Level, m4Fall});
        check("n1_outputs{q,level,fall}", {29'd0, q1, level1, fall1}, {29'd0, m1Q, m1Level, m1Fall});
        if (q4 === 1'b1) begin q4Count++; q4Times.push_back(cyc); end
        if (fall4 === 1'b1) f4Count++;
        if (q1 === 1'b1) q1Count++;
        if (fall1 === 1'b1) f1Count++;
    end

    task automatic hold4(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            d4 = v;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        d4    = 1'bx;
        d1    = 1'bx;

        // Reset with an unknown, then high, input: outputs must stay clean.
        repeat (3) @(negedge clk);
        check("reset_x_q",     {31'd0, q4},     32'd0);
        check("reset_x_fall",  {31'd0, fall4},  32'd0);
        check("reset_x_level", {31'd0, level4}, 32'd0);
        d4 = 1'b1;
        d1 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi_level", {31'd0, level4}, 32'd0);

        // Release, let two high samples accumulate, then reset mid-count.
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midcount_reset_level", {31'd0, level4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Startup with iD already high: four fresh samples then one oQ pulse.
        repeat (3) @(negedge clk);
        check("startup_level_after3", {31'd0, level4}, 32'd0);
        check("startup_q_after3",     {31'd0, q4},     32'd0);
        @(negedge clk);
        check("startup_level_after4", {31'd0, level4}, 32'd1);
        check("startup_q_after4",     {31'd0, q4},     32'd1);
        @(negedge clk);
        check("startup_q_one_cycle",  {31'd0, q4},     32'd0);
        repeat (3) @(negedge clk);
        check("held_high_q_quiet",    {31'd0, q4},     32'd0);

        // Falling transition from level 1.
        hold4(1'b0, 3);
        check("fall_before_4th", {31'd0, fall4}, 32'd0);
        hold4(1'b0, 1);
        check("fall_pulse",      {31'd0, fall4}, 32'd1);
        check("fall_level",      {31'd0, level4}, 32'd0);
        check("fall_no_q",       {31'd0, q4},     32'd0);
        hold4(1'b0, 1);
        check("fall_one_cycle",  {31'd0, fall4}, 32'd0);

        // Glitch rejection: runs of 3 never qualify, even back to back.
        hold4(1'b0, 2);
        q4Count = 0;
        hold4(1'b1, 3);
        hold4(1'b0, 1);
        hold4(1'b1, 3);
        hold4(1'b0, 2);
        check("glitch_no_q",     q4Count,          32'd0);
        check("glitch_level",    {31'd0, level4},  32'd0);
        hold4(1'b1, 4);
        check("glitch_then_4_q", {31'd0, q4},      32'd1);
        hold4(1'b1, 1);
        hold4(1'b0, 6);

        // Periodic input: 25-cycle period, 12 high / 13 low, 10 periods.
        q4Count = 0;
        f4Count = 0;
        q4Times.delete();
        for (int p = 0; p < 10; p++) begin
            hold4(1'b1, 12);
            hold4(1'b0, 13);
        end
        @(negedge clk);
        check("periodic_q_count",    q4Count, 32'd10);
        check("periodic_fall_count", f4Count, 32'd10);
        for (int i = 1; i < q4Times.size(); i++)
            check("periodic_q_spacing", q4Times[i] - q4Times[i-1], 32'd25);

        // N=1 build: toggling every cycle gives a pulse after every sample.
        q1Count = 0;
        f1Count = 0;
        for (int i = 0; i < 20; i++) begin
            d1 = (i % 2 == 0);
            @(negedge clk);
            check("n1_toggle_level", {31'd0, level1}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("n1_toggle_q_count",    q1Count, 32'd10);
        check("n1_toggle_fall_count", f1Count, 32'd10);

        // Randomized runs on both instances, checked by the model each cycle.
        for (int i = 0; i < 600; i++) begin
            logic v;
            int   len;
            v   = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                d4 = v;
                d1 = logic'($urandom_range(0, 1));
                @(negedge clk);
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debounce.md
Name: debounce

Overview:
- Single-clock input debouncer with a rising-edge pulse output.
- Filters a noisy or slowly sampled 1-bit input (typically an already-synchronized foreign clock or strobe) into a clean level.
- Emits a one-cycle strobe on each qualified 0->1 transition of that level.
- Used in the display controller to turn the resynchronized 4 MHz MCK into a 100 MHz-domain dot-clock enable: exactly one pulse per MCK period.

Parameters:
- STABLE_CYCLES, 4: consecutive samples of a new value required before the debounced level changes. Legal range 1..255. Must be less than the shortest expected input half-period (12 at 100 MHz / 4 MHz).
- INIT_LEVEL, 1'b0: debounced level loaded at reset.

Ports:
- iClk, input, 1: system clock; all state updates on the rising edge.
- iRst_n, input, 1: asynchronous active-low reset.
- iD, input, 1: raw input. Already synchronous to iClk; no internal synchronizer. May be X before reset is released.
- oQ, output, 1: registered one-cycle pulse on a qualified rising transition of the debounced level.
- oLevel, output, 1: registered debounced level.
- oFall, output, 1: registered one-cycle pulse on a qualified falling transition.

Behaviour:
- Reset (iRst_n low, asynchronous assert): level <= INIT_LEVEL, counter <= 0, oQ <= 0, oFall <= 0.
  - Reset assertion mid-count discards the partial count.
  - Reset release takes effect at the next iClk edge.
- Counter width: clog2(STABLE_CYCLES+1) bits, unsigned. It never exceeds STABLE_CYCLES-1 and never wraps.
- Each rising iClk edge, with S = sampled iD:
  - S == level: counter <= 0; oQ <= 0; oFall <= 0.
  - S != level and counter == STABLE_CYCLES-1: level <= S; counter <= 0; oQ <= S; oFall <= ~S.
  - S != level otherwise: counter <= counter+1; oQ <= 0; oFall <= 0.
- Latency: iD changes and is sampled different at edges k .. k+N-1 (N = STABLE_CYCLES).
  - oLevel changes after edge k+N-1.
  - oQ (or oFall) is high for exactly the one cycle between edge k+N-1 and edge k+N.
- Glitch rejection: a differing value held for fewer than N consecutive samples causes no level change and no pulse. The counter clears on the first agreeing sample, so the run is not cumulative.
- Pulse width: oQ and oFall never exceed one cycle and are never both high in the same cycle.
- Back-to-back qualified transitions require at least N cycles between them, so pulses are separated by at least N-1 low cycles.
- STABLE_CYCLES = 1: pure registered edge detector. oQ is high the cycle after the first edge where S=1 and level=0.
- Startup: if iD is already 1 at reset release with INIT_LEVEL=0, a single oQ pulse follows after N cycles. This is required behaviour.
- X on iD while in reset must not propagate to any output.

Decomposition:
- No shared package needed.
- Counter-width localparam computed locally from STABLE_CYCLES.
- No sub-modules; the stability counter and edge/strobe registers live in one module.

Test Plan:
- Reset: hold iRst_n=0 with iD=X/1 -> oQ=0, oFall=0, oLevel=0. Assert reset mid-count (2 samples high) -> after release, oLevel stays 0 until 4 fresh high samples.
- Clean rise, N=4: iD 0->1 and held -> oLevel=1 and oQ=1 for exactly one cycle after the 4th high-sampling edge; oQ=0 thereafter while iD stays 1.
- Glitch: iD high 3 cycles, low 1, high 3, low -> oQ never asserts, oLevel stays 0. Then high 4 cycles -> one oQ pulse.
- Falling edge: from level 1, iD low 4 cycles -> oFall one-cycle pulse, oLevel=0, oQ=0.
- Periodic input (25-cycle period, 12/13 split, N=4): 10 periods -> exactly 10 oQ pulses, each 25 cycles apart, and 10 oFall pulses.
- N=1 build: iD toggles every cycle -> oQ pulses on every cycle following a sampled 0->1, and oFall pulses likewise for 1->0.
